// File: rtl/mem_arbiter_if.sv
// Request/grant bundle between the four cores, the broadcast loader and the DRAM arbiter.
interface mem_arbiter_if;
  logic [3:0] rd_req;
  logic [3:0] wr_req;
  logic [3:0] end_process;
  logic       bcast_req;
  logic [3:0] mode;
  logic [3:0] grant;
  logic [3:0] ack;
  logic       bcast_ack;
  logic       busy;

  modport master (
    output rd_req, wr_req, end_process, bcast_req,
    input  mode, grant, ack, bcast_ack, busy
  );

  modport slave (
    input  rd_req, wr_req, end_process, bcast_req,
    output mode, grant, ack, bcast_ack, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for a shared DRAM path: four cores plus a priority broadcast load.
// Each grant holds mode/grant for ACCESS_CYCLES cycles, then a one-cycle DONE pulses the ack.
module mem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [3:0]  IDLE_MODE     = 4'd15
) (
  input logic           clock,
  input logic           reset_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0] state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic       is_bcast;
  logic [7:0] cnt;
  logic [3:0] eligible;
  logic [1:0] pick_idx;
  logic       pick_valid;

  assign eligible = (bus.rd_req | bus.wr_req) & ~bus.end_process;

  // First eligible core at or after ptr, wrapping 3 -> 0.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!pick_valid && eligible[ptr + 2'(i)]) begin
        pick_valid = 1'b1;
        pick_idx   = ptr + 2'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      is_bcast      <= 1'b0;
      cnt           <= '0;
      bus.mode      <= IDLE_MODE;
      bus.grant     <= '0;
      bus.ack       <= '0;
      bus.bcast_ack <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.ack       <= '0;
      bus.bcast_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.bcast_req) begin
            state     <= ACCESS;
            is_bcast  <= 1'b1;
            bus.mode  <= 4'd0;
            bus.grant <= '1;
            bus.busy  <= 1'b1;
            cnt       <= 8'(ACCESS_CYCLES - 1);
          end else if (pick_valid) begin
            state     <= ACCESS;
            is_bcast  <= 1'b0;
            owner     <= pick_idx;
            // Read wins when a core raises both; its write re-arbitrates later.
            bus.mode  <= bus.rd_req[pick_idx] ? ({2'b00, pick_idx} + 4'd1)
                                              : ({2'b00, pick_idx} + 4'd5);
            bus.grant <= 4'b0001 << pick_idx;
            bus.busy  <= 1'b1;
            cnt       <= 8'(ACCESS_CYCLES - 1);
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= DONE;
            bus.mode  <= IDLE_MODE;
            bus.grant <= '0;
            if (is_bcast) bus.bcast_ack <= 1'b1;
            else          bus.ack       <= 4'b0001 << owner;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (!is_bcast) ptr <= owner + 2'd1;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued as stimulus is applied
// and matched by a monitor as each access starts, holds and completes.
module tb_mem_arbiter;

  localparam int unsigned AC = 2;

  typedef struct {
    logic [3:0] mode;
    logic [3:0] grant;
    logic       bcast;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  mem_arbiter_if bus ();

  mem_arbiter #(.ACCESS_CYCLES(AC), .IDLE_MODE(4'd15)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   mon_active = 1'b0;
  int   hold = 0;
  int   n_grants = 0;
  logic [3:0] prev_grant = '0;
  logic [3:0] hold_mask = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] mode, input logic [3:0] grant, input logic bcast);
    exp_t e;
    e.mode  = mode;
    e.grant = grant;
    e.bcast = bcast;
    exp_q.push_back(e);
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      mon_active = 1'b0;
      prev_grant = '0;
    end else begin
      if (bus.ack != '0 || bus.bcast_ack) begin
        if (!mon_active) begin
          check_eq("spurious_ack", {27'd0, bus.bcast_ack, bus.ack}, 32'd0);
        end else begin
          check_eq("hold_len", hold, AC);
          check_eq("ack", bus.ack, cur.bcast ? 4'd0 : cur.grant);
          check_eq("bcast_ack", bus.bcast_ack, cur.bcast);
          check_eq("done_mode", bus.mode, 4'd15);
          check_eq("done_busy", bus.busy, 1'b1);
          mon_active = 1'b0;
        end
      end
      if (bus.grant != '0 && prev_grant == '0) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_grant", bus.grant, 4'd0);
        end else begin
          cur = exp_q.pop_front();
          check_eq("grant", bus.grant, cur.grant);
          check_eq("mode", bus.mode, cur.mode);
          check_eq("busy", bus.busy, 1'b1);
          mon_active = 1'b1;
          hold = 0;
          n_grants++;
        end
      end else if (bus.grant != '0 && mon_active) begin
        check_eq("grant_held", bus.grant, cur.grant);
        check_eq("mode_held", bus.mode, cur.mode);
      end
      if (bus.grant != '0) hold++;
      prev_grant = bus.grant;
    end
  end

  // Requesters drop the acknowledged request (read before write) unless held.
  task automatic service_acks();
    if (bus.bcast_ack) bus.bcast_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.ack[k] && !hold_mask[k]) begin
        if (bus.rd_req[k]) bus.rd_req[k] = 1'b0;
        else               bus.wr_req[k] = 1'b0;
      end
    end
  endtask

  task automatic wait_grants(input int target);
    int budget = 300;
    while (n_grants < target && budget > 0) begin
      @(negedge clock);
      service_acks();
      budget--;
    end
    if (n_grants < target) check_eq("timeout_grants", n_grants, target);
  endtask

  task automatic drain();
    int budget = 300;
    do begin
      @(negedge clock);
      service_acks();
      budget--;
    end while ((exp_q.size() != 0 || mon_active) && budget > 0);
    if (exp_q.size() != 0 || mon_active) check_eq("timeout_drain", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    reset_n         = 1'b0;
    bus.rd_req      = '0;
    bus.wr_req      = '0;
    bus.end_process = '0;
    bus.bcast_req   = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_mode", bus.mode, 4'd15);
    check_eq("rst_grant", bus.grant, 4'd0);
    check_eq("rst_ack", bus.ack, 4'd0);
    check_eq("rst_bcast_ack", bus.bcast_ack, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    reset_n = 1'b1;

    // Single read by core 2.
    push_exp(4'd2, 4'b0010, 1'b0);
    bus.rd_req = 4'b0010;
    drain();

    // Core 3 write aborted by reset; ptr must return to 0.
    base = n_grants;
    push_exp(4'd7, 4'b0100, 1'b0);
    bus.wr_req = 4'b0100;
    wait_grants(base + 1);
    @(negedge clock);
    bus.wr_req = '0;
    reset_n = 1'b0;
    #1;
    check_eq("abort_mode", bus.mode, 4'd15);
    check_eq("abort_grant", bus.grant, 4'd0);
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_ack", bus.ack, 4'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Continuous read requests from all cores: round-robin from core 1.
    base = n_grants;
    push_exp(4'd1, 4'b0001, 1'b0);
    push_exp(4'd2, 4'b0010, 1'b0);
    push_exp(4'd3, 4'b0100, 1'b0);
    push_exp(4'd4, 4'b1000, 1'b0);
    push_exp(4'd1, 4'b0001, 1'b0);
    hold_mask  = 4'b1111;
    bus.rd_req = 4'b1111;
    wait_grants(base + 5);
    hold_mask  = '0;
    bus.rd_req = '0;
    drain();

    // Broadcast and write raised together: broadcast first.
    push_exp(4'd0, 4'b1111, 1'b1);
    push_exp(4'd7, 4'b0100, 1'b0);
    bus.wr_req    = 4'b0100;
    bus.bcast_req = 1'b1;
    drain();

    // Finished core is ignored until end_process clears.
    bus.rd_req      = 4'b1000;
    bus.end_process = 4'b1000;
    repeat (6) begin
      @(negedge clock);
      check_eq("ended_busy", bus.busy, 1'b0);
      check_eq("ended_mode", bus.mode, 4'd15);
    end
    push_exp(4'd4, 4'b1000, 1'b0);
    bus.end_process = '0;
    drain();

    // Read and write from core 1: read first, then the write.
    push_exp(4'd1, 4'b0001, 1'b0);
    push_exp(4'd5, 4'b0001, 1'b0);
    bus.rd_req = 4'b0001;
    bus.wr_req = 4'b0001;
    drain();

    // Request dropped mid-access still completes with ack.
    base = n_grants;
    push_exp(4'd3, 4'b0100, 1'b0);
    bus.rd_req = 4'b0100;
    wait_grants(base + 1);
    bus.rd_req = '0;
    drain();

    // Broadcast arriving during an access wins next; ptr unchanged by broadcast.
    base = n_grants;
    push_exp(4'd2, 4'b0010, 1'b0);
    bus.rd_req = 4'b0010;
    wait_grants(base + 1);
    push_exp(4'd0, 4'b1111, 1'b1);
    push_exp(4'd4, 4'b1000, 1'b0);
    push_exp(4'd1, 4'b0001, 1'b0);
    bus.bcast_req = 1'b1;
    bus.rd_req    = 4'b1011;
    drain();

    repeat (4) @(negedge clock);
    check_eq("final_busy", bus.busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
